// File: rtl/ceiling_expand_pkg.sv
// Shared definitions for the ceiling expand path: pad/saturation mode names,
// low-pad width derivation and the reference code-to-word expansion.
package ceiling_expand_pkg;

  localparam string PAD_ZERO = "ZERO";
  localparam string PAD_HALF = "HALF";
  localparam string SAT_ON   = "TRUE";
  localparam string SAT_OFF  = "FALSE";

  // Words are built in a 64-bit scratch value, so DSIZE is limited to 63.
  localparam int MAX_DSIZE = 63;

  function automatic int lsize_of(input int dsize, input int csize, input int osize);
    return dsize - csize - osize;
  endfunction

  function automatic bit cfg_ok(input int dsize, input int csize, input int osize,
                                input bit pad_half);
    return (dsize <= MAX_DSIZE) && (osize >= 1) && (csize >= 0) && (csize < dsize) &&
           (osize <= dsize - csize) && (!pad_half || (lsize_of(dsize, csize, osize) >= 1));
  endfunction

  // Rebuild a wide word from a narrow code: zero MSB field, code, then low pad.
  // An all-ones code optionally decodes to full scale.
  function automatic logic [63:0] expand_word(input logic [63:0] code, input int dsize,
                                              input int csize, input int osize,
                                              input bit sat_decode, input bit pad_half);
    logic [63:0] mask;
    logic [63:0] word;
    int          lsize;
    lsize = lsize_of(dsize, csize, osize);
    mask  = (64'd1 << osize) - 64'd1;
    word  = 64'd0;
    if (cfg_ok(dsize, csize, osize, pad_half)) begin
      if (((code & mask) == mask) && sat_decode) begin
        word = (64'd1 << dsize) - 64'd1;
      end else begin
        word = (code & mask) << lsize;
        if (pad_half) word = word | (64'd1 << (lsize - 1));
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/ceiling_expand_stage.sv
// One-entry valid/ready register slice; loads whenever it is empty or its
// content is being taken downstream in the same cycle.
module ceiling_expand_stage #(
  parameter int W = 17
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Slice register: advance on ready, clear on reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/ceiling_expand.sv
// Expands an OSIZE narrow code back into a DSIZE word through a two-stage
// valid/ready pipeline and counts accepted saturated (all-ones) codes.
module ceiling_expand
  import ceiling_expand_pkg::*;
#(
  parameter int    DSIZE      = 16,
  parameter int    CSIZE      = 4,
  parameter int    OSIZE      = 8,
  parameter string PAD_MODE   = "ZERO",
  parameter string SAT_DECODE = "TRUE",
  parameter int    CNT_SIZE   = 16
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OSIZE-1:0]    indata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DSIZE-1:0]    outdata,
  output logic                out_sat,
  input  logic                clr_count,
  output logic [CNT_SIZE-1:0] sat_count
);

  localparam bit PAD_IS_HALF = (PAD_MODE == PAD_HALF);
  localparam bit SAT_IS_ON   = (SAT_DECODE == SAT_ON);
  localparam bit CFG_OK      = cfg_ok(DSIZE, CSIZE, OSIZE, PAD_IS_HALF);
  localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;

  if (!CFG_OK) begin : g_bad_cfg
    $warning("ceiling_expand: invalid DSIZE/CSIZE/OSIZE/PAD_MODE combination, outdata held at 0");
  end

  logic             sat_p0;
  logic [DSIZE-1:0] word_p0;
  logic             vld_p1;
  logic             s2_ready;
  logic [DSIZE:0]   pay_p1;
  logic [DSIZE:0]   pay_p2;

  assign sat_p0  = &indata;
  assign word_p0 = CFG_OK ? DSIZE'(expand_word(64'(indata), DSIZE, CSIZE, OSIZE,
                                               SAT_IS_ON, PAD_IS_HALF)) : '0;

  // ---- stage 1: expanded word + sat flag ----
  ceiling_expand_stage #(.W(DSIZE + 1)) u_stage1 (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({sat_p0, word_p0}),
    .out_valid (vld_p1),
    .out_ready (s2_ready),
    .out_data  (pay_p1)
  );

  // ---- stage 2: output register ----
  ceiling_expand_stage #(.W(DSIZE + 1)) u_stage2 (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (vld_p1),
    .in_ready  (s2_ready),
    .in_data   (pay_p1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_p2)
  );

  assign out_sat = pay_p2[DSIZE];
  assign outdata = pay_p2[DSIZE-1:0];

  logic sat_acc;
  assign sat_acc = in_valid && in_ready && sat_p0;

  // Saturation event counter: clear wins over the old value, a same-cycle
  // saturated accept still counts, and the count sticks at all-ones.
  always_ff @(posedge clock) begin
    if (rst) begin
      sat_count <= '0;
    end else if (clr_count) begin
      sat_count <= sat_acc ? CNT_SIZE'(1) : '0;
    end else if (sat_acc && (sat_count != CNT_MAX)) begin
      sat_count <= sat_count + CNT_SIZE'(1);
    end
  end

endmodule

// File: tb/tb_ceiling_expand.sv
// Scoreboard bench for ceiling_expand: three instances (default, HALF pad,
// no sat decode with a 2-bit counter) share one input stream.
module tb_ceiling_expand;

  logic        clock = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  indata;
  logic        out_ready;
  logic        clr_count;

  logic        ir_a, ir_b, ir_c;
  logic        ov_a, ov_b, ov_c;
  logic [15:0] od_a, od_b, od_c;
  logic        os_a, os_b, os_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int checks = 0;
  int errors = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];

  always #5 clock = ~clock;

  ceiling_expand #(.DSIZE(16), .CSIZE(4), .OSIZE(8), .PAD_MODE("ZERO"),
                   .SAT_DECODE("TRUE"), .CNT_SIZE(16)) dut_a (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .indata(indata),
    .out_valid(ov_a), .out_ready(out_ready), .outdata(od_a), .out_sat(os_a),
    .clr_count(clr_count), .sat_count(cnt_a));

  ceiling_expand #(.DSIZE(16), .CSIZE(4), .OSIZE(8), .PAD_MODE("HALF"),
                   .SAT_DECODE("TRUE"), .CNT_SIZE(16)) dut_b (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .indata(indata),
    .out_valid(ov_b), .out_ready(out_ready), .outdata(od_b), .out_sat(os_b),
    .clr_count(clr_count), .sat_count(cnt_b));

  ceiling_expand #(.DSIZE(16), .CSIZE(4), .OSIZE(8), .PAD_MODE("ZERO"),
                   .SAT_DECODE("FALSE"), .CNT_SIZE(2)) dut_c (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .indata(indata),
    .out_valid(ov_c), .out_ready(out_ready), .outdata(od_c), .out_sat(os_c),
    .clr_count(clr_count), .sat_count(cnt_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hand-computed {sat, word} per instance (0: ZERO/TRUE, 1: HALF/TRUE, 2: ZERO/FALSE).
  function automatic logic [16:0] exp_of(input int d, input logic [7:0] c);
    logic [16:0] r;
    case (c)
      8'h5A:   r = (d == 1) ? {1'b0, 16'h05A8} : {1'b0, 16'h05A0};
      8'hFF:   r = (d == 2) ? {1'b1, 16'h0FF0} : {1'b1, 16'hFFFF};
      8'h01:   r = (d == 1) ? {1'b0, 16'h0018} : {1'b0, 16'h0010};
      8'h02:   r = (d == 1) ? {1'b0, 16'h0028} : {1'b0, 16'h0020};
      8'h03:   r = (d == 1) ? {1'b0, 16'h0038} : {1'b0, 16'h0030};
      8'h80:   r = (d == 1) ? {1'b0, 16'h0808} : {1'b0, 16'h0800};
      8'h00:   r = (d == 1) ? {1'b0, 16'h0008} : {1'b0, 16'h0000};
      default: r = 'x;
    endcase
    return r;
  endfunction

  // Push expected responses on every accepted code.
  always @(posedge clock) begin
    if (!rst && in_valid && ir_a) begin
      q0.push_back(exp_of(0, indata));
      q1.push_back(exp_of(1, indata));
      q2.push_back(exp_of(2, indata));
    end
  end

  task automatic mon(input int idx, input logic [15:0] data, input logic sat);
    logic [16:0] e;
    int          n;
    n = (idx == 0) ? q0.size() : (idx == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_out[%0d]: got %0h, expected no output", idx, {sat, data});
    end else begin
      if (idx == 0) e = q0.pop_front();
      else if (idx == 1) e = q1.pop_front();
      else e = q2.pop_front();
      check($sformatf("out[%0d]", idx), {15'd0, sat, data}, {15'd0, e});
    end
  endtask

  // Output monitor: a word is taken when out_valid && out_ready at the next edge.
  always @(negedge clock) begin
    #1;
    if (!rst && out_ready) begin
      if (ov_a) mon(0, od_a, os_a);
      if (ov_b) mon(1, od_b, os_b);
      if (ov_c) mon(2, od_c, os_c);
    end
  end

  // Present a code from a negedge and hold it until accepted; returns at the
  // negedge after the accepting edge.
  task automatic send(input logic [7:0] code);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    in_valid = 1'b1;
    indata = code;
    while (!acc && n < 50) begin
      @(posedge clock);
      acc = ir_a;
      n++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept, expected accept of %0h", code);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("drain_left", q0.size() + q1.size() + q2.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    indata = 8'h00;
    out_ready = 1'b1;
    clr_count = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", ov_a, 0);
    check("rst_outdata", od_a, 0);
    check("rst_out_sat", os_a, 0);
    check("rst_sat_count", cnt_a, 0);
    check("rst_in_ready", ir_a, 1);
    rst = 1'b0;

    // Plain code, HALF pad, saturated code with and without sat decode.
    send(8'h5A);
    check("cnt_after_5a", cnt_a, 0);
    send(8'hFF);
    check("cnt_after_ff", cnt_a, 1);
    check("cnt_c_after_ff", cnt_c, 1);
    drain();

    // Clear alone.
    clr_count = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clr_count = 1'b0;
    check("clr_alone_a", cnt_a, 0);
    check("clr_alone_c", cnt_c, 0);

    // Counter saturation at 2 bits, then clear with a simultaneous sat accept.
    for (int i = 0; i < 4; i++) begin
      send(8'hFF);
      check($sformatf("cnt_c_%0d", i), cnt_c, (i < 3) ? i + 1 : 3);
      check($sformatf("cnt_a_%0d", i), cnt_a, i + 1);
    end
    clr_count = 1'b1;
    send(8'hFF);
    clr_count = 1'b0;
    check("clr_with_sat_c", cnt_c, 1);
    check("clr_with_sat_a", cnt_a, 1);
    drain();

    // Backpressure: two accepts fill the pipe, the third waits.
    out_ready = 1'b0;
    send(8'h01);
    send(8'h02);
    in_valid = 1'b1;
    indata = 8'h03;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("stall_in_ready", ir_a, 0);
      check("stall_out_valid", ov_a, 1);
      check("stall_outdata", od_a, 16'h0010);
    end
    out_ready = 1'b1;
    send(8'h03);
    drain();

    // Reset with both stages full drops everything in flight.
    out_ready = 1'b0;
    send(8'h80);
    send(8'h00);
    check("full_in_ready", ir_a, 0);
    rst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midrst_out_valid", ov_a, 0);
    check("midrst_outdata", od_a, 0);
    check("midrst_out_sat", os_a, 0);
    check("midrst_sat_count", cnt_a, 0);
    check("midrst_in_ready", ir_a, 1);
    q0.delete();
    q1.delete();
    q2.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    send(8'h5A);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
